// File: rtl/fire_expand_seq.sv
// Window/tap address sequencer for a KxK stride-1 convolution layer with zero padding.
// Issues one tap per non-stalled cycle and tags MAC results with their output pixel.
module fire_expand_seq #(
  parameter int W_IN       = 64,
  parameter int CHIN       = 16,
  parameter int KERNEL_DIM = 3,
  parameter int LAT        = 2,
  localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int PIX  = W_IN * W_IN,
  localparam int AW   = (PIX * CHIN > 1) ? $clog2(PIX * CHIN) : 1,
  localparam int WW   = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int XW   = (W_IN > 1) ? $clog2(W_IN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic [AW-1:0] ifm_addr,
  output logic          pad_zero,
  output logic [WW-1:0] weight_addr,
  output logic          mac_clr,
  output logic          sample_valid,
  output logic [XW-1:0] out_x,
  output logic [XW-1:0] out_y,
  output logic          busy,
  output logic          done
);

  localparam int PAD = (KERNEL_DIM - 1) / 2;
  localparam int CW  = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int KW  = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] c_q;
  logic [KW-1:0] kx_q, ky_q;
  logic [WW-1:0] t_q;
  logic [XW-1:0] x_q, y_q;

  logic          vld_p [LAT];
  logic [XW-1:0] x_p   [LAT];
  logic [XW-1:0] y_p   [LAT];

  logic issue;
  logic last_c, last_kx, last_ky, last_tap, last_x, last_y;
  logic last_win_out;

  assign issue    = (state_q == RUN) && !stall;
  assign last_c   = (c_q  == CW'(CHIN - 1));
  assign last_kx  = (kx_q == KW'(KERNEL_DIM - 1));
  assign last_ky  = (ky_q == KW'(KERNEL_DIM - 1));
  assign last_tap = last_c && last_kx && last_ky;
  assign last_x   = (x_q == XW'(W_IN - 1));
  assign last_y   = (y_q == XW'(W_IN - 1));

  assign sample_valid = vld_p[LAT-1] && !stall;
  assign out_x        = x_p[LAT-1];
  assign out_y        = y_p[LAT-1];
  assign last_win_out = (x_p[LAT-1] == XW'(W_IN - 1)) && (y_p[LAT-1] == XW'(W_IN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && last_tap && last_x && last_y) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (sample_valid && last_win_out) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap/window counters: channel fastest, then kx, ky; windows x fastest, then y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q  <= '0;
      kx_q <= '0;
      ky_q <= '0;
      t_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (issue) begin
      if (last_c) begin
        c_q <= '0;
        if (last_kx) begin
          kx_q <= '0;
          ky_q <= last_ky ? '0 : ky_q + 1'b1;
        end else begin
          kx_q <= kx_q + 1'b1;
        end
      end else begin
        c_q <= c_q + 1'b1;
      end
      t_q <= last_tap ? '0 : t_q + 1'b1;
      if (last_tap) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // Stage _p0.._p(LAT-1): window tag follows the MAC latency, frozen under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i] <= 1'b0;
        x_p[i]   <= '0;
        y_p[i]   <= '0;
      end
    end else if (!stall) begin
      vld_p[0] <= issue && last_tap;
      x_p[0]   <= x_q;
      y_p[0]   <= y_q;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        x_p[i]   <= x_p[i-1];
        y_p[i]   <= y_p[i-1];
      end
    end
  end

  // Address generation for the tap currently presented (held while stalled)
  always_comb begin
    int ix;
    int iy;
    ix          = 0;
    iy          = 0;
    ifm_addr    = '0;
    pad_zero    = 1'b0;
    weight_addr = '0;
    mac_clr     = 1'b0;
    if (state_q == RUN) begin
      weight_addr = t_q;
      mac_clr     = (t_q == '0) && !stall;
      ix = int'(x_q) + int'(kx_q) - PAD;
      iy = int'(y_q) + int'(ky_q) - PAD;
      if (ix >= 0 && ix < W_IN && iy >= 0 && iy < W_IN) begin
        ifm_addr = AW'((iy * W_IN + ix) * CHIN + int'(c_q));
      end else begin
        pad_zero = 1'b1;
      end
    end
  end

endmodule
